// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with blank gaps and frame-synchronous loads.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 3,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   localparam int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [DIG_W-1:0]        digit_idx,
   output logic                    frame_start
);

   localparam int PRESC_W = $clog2(REFRESH_DIV);
   localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [DIG_W-1:0]   DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [PRESC_W-1:0]      presc_q, presc_d;
   logic [BLANK_W-1:0]      blank_q, blank_d;
   logic [DIG_W-1:0]        digit_q, digit_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_start_q, frame_start_d;
   logic                    advance;
   logic                    xfer;
   logic [3:0]              nib;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

`ifdef SEG_LZB_EN
   // Digit k is a leading zero when it and every more-significant nibble are zero.
   function automatic logic lzb_blank(input logic [4*NUM_DIGITS-1:0] sh,
                                      input logic [DIG_W-1:0] k);
      logic b;
      b = (k != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((DIG_W'(i) >= k) && (sh[4*i +: 4] != 4'h0)) b = 1'b0;
      end
      return b;
   endfunction
`endif

   always_comb begin
      state_d       = state_q;
      presc_d       = presc_q;
      blank_d       = blank_q;
      digit_d       = digit_q;
      shadow_d      = shadow_q;
      pending_d     = load ? digits_in : pending_q;
      frame_start_d = 1'b0;
      advance       = 1'b0;
      xfer          = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         presc_d = '0;
         blank_d = '0;
         digit_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SHOW;
               presc_d = '0;
               digit_d = '0;
               xfer    = 1'b1;
            end
            ST_SHOW: begin
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  if (BLANK_CYCLES > 0) begin
                     state_d = ST_BLANK;
                     blank_d = '0;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end
            ST_BLANK: begin
               if (blank_q == BLANK_LAST) advance = 1'b1;
               else blank_d = blank_q + BLANK_W'(1);
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Moving to the next digit; wrapping to digit 0 starts a new frame.
      if (advance) begin
         state_d = ST_SHOW;
         if (digit_q == DIGIT_LAST) begin
            digit_d = '0;
            xfer    = 1'b1;
         end else begin
            digit_d = digit_q + DIG_W'(1);
         end
      end

      if (xfer) begin
         shadow_d      = pending_q;
         frame_start_d = 1'b1;
      end

      // Pins are computed from the next state so they change together with it.
      seg_d = 7'b1111111;
      an_d  = '1;
      nib   = 4'h0;
      if (state_d == ST_SHOW) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_d == DIG_W'(k)) begin
               nib     = shadow_d[4*k +: 4];
               an_d[k] = 1'b0;
            end
         end
         seg_d = hex_decode(nib);
`ifdef SEG_LZB_EN
         if (lzb_blank(shadow_d, digit_d)) seg_d = 7'b1111111;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         presc_q       <= '0;
         blank_q       <= '0;
         digit_q       <= '0;
         pending_q     <= '0;
         shadow_q      <= '0;
         seg_q         <= 7'b1111111;
         an_q          <= '1;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         blank_q       <= blank_d;
         digit_q       <= digit_d;
         pending_q     <= pending_d;
         shadow_q      <= shadow_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign digit_idx   = digit_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (with and without blank gap) checked each
// cycle against a frame-position model, plus directed literal checks.
module tb_seg_scan_driver;

   localparam int ND = 3;
   localparam int R  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [11:0] digits_in = '0;

   logic [6:0] seg0, seg1;
   logic [2:0] an0, an1;
   logic [1:0] idx0, idx1;
   logic       fs0, fs1;

   int total = 0;
   int bad = 0;
   bit chk_on = 0;

   int          mn[2]   = '{-1, -1};
   logic [11:0] mpend[2] = '{12'h0, 12'h0};
   logic [11:0] msh[2]   = '{12'h0, 12'h0};
   logic        mfs[2]   = '{1'b0, 1'b0};

   logic [2:0] an_tab[16];
   logic [6:0] lz_exp;

   seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(R), .BLANK_CYCLES(1)) dut_b1 (
      .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
      .seg(seg0), .an(an0), .digit_idx(idx0), .frame_start(fs0));

   seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_b0 (
      .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
      .seg(seg1), .an(an1), .digit_idx(idx1), .frame_start(fs1));

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   function automatic int blank_of(input int c);
      return (c == 0) ? 1 : 0;
   endfunction

   // n = cycles since the scan (re)started; -1 means idle.
   function automatic logic [12:0] exp_out(input int n, input logic [11:0] sh,
                                           input logic fs, input int b);
      int p, pos, dg, w;
      logic [11:0] t;
      logic [6:0]  s;
      logic [2:0]  a;
      if (n < 0) return {3'b111, 7'b1111111, 2'd0, 1'b0};
      p   = R + b;
      pos = n % (ND * p);
      dg  = pos / p;
      w   = pos % p;
      a   = 3'b111;
      s   = 7'b1111111;
      if (w < R) begin
         a = ~(3'b001 << dg);
         t = sh >> (4 * dg);
         s = hex7(t[3:0]);
`ifdef SEG_LZB_EN
         if (dg > 0 && t == 12'h0) s = 7'b1111111;
`endif
      end
      return {a, s, 2'(dg), fs};
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            mn[c]    <= -1;
            mpend[c] <= '0;
            msh[c]   <= '0;
            mfs[c]   <= 1'b0;
         end else begin
            if (!en) begin
               mn[c]  <= -1;
               mfs[c] <= 1'b0;
            end else begin
               mn[c] <= mn[c] + 1;
               if ((mn[c] + 1) % (ND * (R + blank_of(c))) == 0) begin
                  msh[c] <= mpend[c];
                  mfs[c] <= 1'b1;
               end else begin
                  mfs[c] <= 1'b0;
               end
            end
            if (load) mpend[c] <= digits_in;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         chk("model_b1", {19'd0, an0, seg0, idx0, fs0}, {19'd0, exp_out(mn[0], msh[0], mfs[0], 1)});
         chk("model_b0", {19'd0, an1, seg1, idx1, fs1}, {19'd0, exp_out(mn[1], msh[1], mfs[1], 0)});
      end
   end

   task automatic wait_state(input logic [2:0] a, input logic [1:0] ix, input string nm);
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (an0 === a && idx0 === ix) hit = 1;
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, an=%b idx=%0d required an=%b idx=%0d", nm, an0, idx0, a, ix);
      end
   endtask

   task automatic wait_fs(input string nm);
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (fs0 === 1'b1) hit = 1;
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, frame_start=%b required 1", nm, fs0);
      end
   endtask

   initial begin
`ifdef SEG_LZB_EN
      lz_exp = 7'b1111111;
`else
      lz_exp = 7'b0000001;
`endif
      an_tab = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111,
                 3'b101, 3'b101, 3'b101, 3'b101, 3'b111,
                 3'b011, 3'b011, 3'b011, 3'b011, 3'b111, 3'b110};

      // Power-up reset
      #1 rst = 1'b1;
      #1;
      chk("rst_an", an0, 3'b111);
      chk("rst_seg", seg0, 7'b1111111);
      chk("rst_idx", idx0, 2'd0);
      chk("rst_fs", fs0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_on = 1;

      // Load 0A8 then enable: scan order and per-digit decode
      @(negedge clk);
      load = 1'b1;
      digits_in = 12'h0A8;
      @(negedge clk);
      load = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk($sformatf("scan_an_c%0d", c), an0, an_tab[c]);
         if (c == 0) begin
            chk("scan_seg_d0", seg0, 7'b0000000);
            chk("scan_fs_first", fs0, 1'b1);
         end
         if (c == 3) chk("scan_fs_once", fs0, 1'b0);
         if (c == 5) chk("scan_seg_d1", seg0, 7'b0001000);
         if (c == 10) chk("scan_seg_d2", seg0, lz_exp);
         if (c == 15) chk("scan_fs_wrap", fs0, 1'b1);
      end

      // Load mid-frame applies only at the next wrap
      wait_state(3'b101, 2'd1, "midload_wait");
      load = 1'b1;
      digits_in = 12'h123;
      @(negedge clk);
      load = 1'b0;
      chk("midload_old_d1", seg0, 7'b0001000);
      wait_fs("midload_fs");
      chk("midload_new_d0", seg0, 7'b0000110);

      // Load on the transfer edge: old pending shows this frame
      wait_state(3'b111, 2'd2, "edge_wait");
      load = 1'b1;
      digits_in = 12'h456;
      @(negedge clk);
      load = 1'b0;
      chk("edge_fs", fs0, 1'b1);
      chk("edge_old_d0", seg0, 7'b0000110);
      wait_fs("edge_fs2");
      chk("edge_new_d0", seg0, 7'b0100000);

      // Disable during digit 2, then restart
      wait_state(3'b011, 2'd2, "dis_wait");
      en = 1'b0;
      @(negedge clk);
      chk("dis_an", an0, 3'b111);
      chk("dis_seg", seg0, 7'b1111111);
      chk("dis_idx", idx0, 2'd0);
      en = 1'b1;
      @(negedge clk);
      chk("restart_fs", fs0, 1'b1);
      chk("restart_an", an0, 3'b110);
      chk("restart_seg", seg0, 7'b0100000);
      chk("restart_an_nogap", an1, 3'b110);
      repeat (4) @(negedge clk);
      chk("gap_an_b1", an0, 3'b111);
      chk("gap_an_b0", an1, 3'b101);

      // Leading zeros
      @(negedge clk);
      load = 1'b1;
      digits_in = 12'h005;
      @(negedge clk);
      load = 1'b0;
      wait_fs("lzb_fs");
      chk("lzb_d0", seg0, 7'b0100100);
      wait_state(3'b101, 2'd1, "lzb_wait1");
      chk("lzb_d1", seg0, lz_exp);
      wait_state(3'b011, 2'd2, "lzb_wait2");
      chk("lzb_d2", seg0, lz_exp);

      // Randomized loads and enable toggling
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 5) == 0);
         if (load) begin
            case ($urandom_range(0, 2))
               0: digits_in = 12'($urandom);
               1: digits_in = 12'($urandom_range(0, 255));
               default: digits_in = 12'($urandom_range(0, 15));
            endcase
         end
         if (en) en = ($urandom_range(0, 59) != 0);
         else en = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      load = 1'b0;
      en = 1'b1;

      // Asynchronous reset between clock edges
      wait_state(3'b101, 2'd1, "arst_wait");
      #2 rst = 1'b1;
      #1;
      chk("arst_an", an0, 3'b111);
      chk("arst_seg", seg0, 7'b1111111);
      chk("arst_idx", idx0, 2'd0);
      chk("arst_fs", fs0, 1'b0);
      chk("arst_an_b0", an1, 3'b111);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
